fetch_align_buffer: RTL and testbench

FETCH_ALIGN_BUFFER -- requirements
Module: fetch_align_buffer

---
 rtl/fetch_align_buffer.sv | 98 +++++++++
 tb/tb_fetch_align_buffer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fetch_align_buffer.sv
// fetch_align_buffer: 4-halfword fetch FIFO aligning 16/32-bit instructions from a unified memory; RVC handling compiled in with FETCH_RVC_EN
module fetch_align_buffer #(
  parameter logic [8:0] RESET_PC = 9'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        isInst,
  input  logic [31:0] mem_inst,
  output logic [8:0]  fetch_addr,
  input  logic        redirect,
  input  logic [8:0]  redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [8:0]  out_pc,
  output logic        out_compressed
);
  logic [15:0] r_buf [4];
  logic [1:0]  r_head;
  logic [2:0]  r_count;
  logic [8:0]  r_fetch;
  logic [8:0]  r_pc;
  logic        r_half;
  logic        w_comp;
  logic [8:0]  w_redir_pc;
  logic        w_redir_half;
  logic        w_reset_half;
  logic        w_unused;
  logic        w_valid;
  logic        w_fire;
  logic [2:0]  w_pop;
  logic        w_push_ok;
  logic [2:0]  w_push_n;
  logic [1:0]  w_next;
  logic [1:0]  w_tail;
  logic [1:0]  w_tail1;
`ifdef FETCH_RVC_EN
  assign w_comp       = r_buf[r_head][1:0] != 2'b11;
  assign w_redir_pc   = {redirect_pc[8:1], 1'b0};
  assign w_redir_half = redirect_pc[1];
  assign w_reset_half = RESET_PC[1];
  assign w_unused     = redirect_pc[0];
`else
  assign w_comp       = 1'b0;
  assign w_redir_pc   = {redirect_pc[8:2], 2'b00};
  assign w_redir_half = 1'b0;
  assign w_reset_half = 1'b0;
  assign w_unused     = ^redirect_pc[1:0];
`endif
  assign w_next    = r_head + 2'd1;
  assign w_tail    = r_head + r_count[1:0];
  assign w_tail1   = w_tail + 2'd1;
  assign w_valid   = (r_count >= 3'd2) || ((r_count != 3'd0) && w_comp);
  assign w_fire    = w_valid && out_ready;
  assign w_pop     = w_fire ? (w_comp ? 3'd1 : 3'd2) : 3'd0;
  assign w_push_ok = isInst && ((r_count - w_pop) <= 3'd2);
  assign w_push_n  = w_push_ok ? (r_half ? 3'd1 : 3'd2) : 3'd0;
  assign fetch_addr     = r_fetch;
  assign out_pc         = r_pc;
  assign out_valid      = w_valid;
  assign out_compressed = w_valid && w_comp;
  assign out_inst       = !w_valid ? 32'h0 : (w_comp ? {16'h0, r_buf[r_head]} : {r_buf[w_next], r_buf[r_head]});
  // queue bookkeeping: redirect flushes, otherwise net push/pop update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= 3'd0;
      r_head  <= 2'd0;
      r_fetch <= {RESET_PC[8:2], 2'b00};
      r_pc    <= RESET_PC;
      r_half  <= w_reset_half;
    end else if (redirect) begin
      r_count <= 3'd0;
      r_head  <= 2'd0;
      r_fetch <= {redirect_pc[8:2], 2'b00};
      r_pc    <= w_redir_pc;
      r_half  <= w_redir_half;
    end else begin
      r_count <= r_count - w_pop + w_push_n;
      r_head  <= r_head + w_pop[1:0];
      r_pc    <= r_pc + {5'd0, w_pop, 1'b0};
      if (w_push_ok) begin
        r_fetch <= r_fetch + 9'd4;
        r_half  <= 1'b0;
      end
    end
  end
  // parcel storage: append the fetched halfwords at the tail, upper only after a mid-word redirect
  always_ff @(posedge clk) begin
    if (w_push_ok && !redirect) begin
      if (r_half) begin
        r_buf[w_tail] <= mem_inst[31:16];
      end else begin
        r_buf[w_tail]  <= mem_inst[15:0];
        r_buf[w_tail1] <= mem_inst[31:16];
      end
    end
  end
endmodule

// File: tb/tb_fetch_align_buffer.sv
// tb_fetch_align_buffer: directed checks of fetch_align_buffer in whichever FETCH_RVC_EN build is compiled
module tb_fetch_align_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        isInst = 1'b0;
  logic        redirect = 1'b0;
  logic [8:0]  redirect_pc = 9'd0;
  logic        out_ready = 1'b0;
  logic [31:0] mem [128];
  logic [31:0] mem_inst;
  logic [8:0]  fetch_addr;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [8:0]  out_pc;
  logic        out_compressed;
  int errs = 0;
  int checks = 0;
  fetch_align_buffer dut (
    .clk(clk), .rst(rst), .isInst(isInst), .mem_inst(mem_inst), .fetch_addr(fetch_addr),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_compressed(out_compressed)
  );
  assign mem_inst = mem[fetch_addr[8:2]];
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic expect_out(input string tag, input logic [31:0] inst, input logic [8:0] pc, input logic c);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_inst"}, out_inst, inst);
    chk({tag, "_pc"}, 32'(out_pc), 32'(pc));
    chk({tag, "_comp"}, 32'(out_compressed), 32'(c));
    tick();
  endtask
  task automatic redir(input string tag, input logic [8:0] pc);
    logic [8:0] exp_pc;
`ifdef FETCH_RVC_EN
    exp_pc = {pc[8:1], 1'b0};
`else
    exp_pc = {pc[8:2], 2'b00};
`endif
    redirect = 1'b1;
    redirect_pc = pc;
    tick();
    redirect = 1'b0;
    chk({tag, "_fetch"}, 32'(fetch_addr), 32'({pc[8:2], 2'b00}));
    chk({tag, "_flush"}, 32'(out_valid), 32'd0);
    chk({tag, "_pc"}, 32'(out_pc), 32'(exp_pc));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h00010013;
    mem[0]   = 32'h00000583;
    mem[1]   = 32'h00401603;
    mem[2]   = 32'h00C58593;
    mem[25]  = 32'h00B50533;
    mem[47]  = 32'h848944C5;
    mem[48]  = 32'h0033E099;
    mem[49]  = 32'h12340000;
    mem[127] = 32'h00A00013;
    #2 rst = 1'b0;
    tick(2);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_fetch", 32'(fetch_addr), 32'd0);
    chk("rst_pc", 32'(out_pc), 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_comp", 32'(out_compressed), 32'd0);
    rst = 1'b1;
    isInst = 1'b1;
    out_ready = 1'b1;
    expect_out("w0", 32'h00000583, 9'd0, 1'b0);
    expect_out("w1", 32'h00401603, 9'd4, 1'b0);
    redir("r188", 9'd188);
`ifdef FETCH_RVC_EN
    expect_out("c188", 32'h000044C5, 9'd188, 1'b1);
    expect_out("c190", 32'h00008489, 9'd190, 1'b1);
    expect_out("c192", 32'h0000E099, 9'd192, 1'b1);
    expect_out("s194", 32'h00000033, 9'd194, 1'b0);
    expect_out("c198", 32'h00001234, 9'd198, 1'b1);
`else
    expect_out("w188", 32'h848944C5, 9'd188, 1'b0);
    expect_out("w192", 32'h0033E099, 9'd192, 1'b0);
    expect_out("w196", 32'h12340000, 9'd196, 1'b0);
`endif
    redir("r190", 9'd190);
`ifdef FETCH_RVC_EN
    expect_out("h190", 32'h00008489, 9'd190, 1'b1);
`else
    expect_out("h190", 32'h848944C5, 9'd188, 1'b0);
`endif
    redir("r508", 9'd508);
    expect_out("w508", 32'h00A00013, 9'd508, 1'b0);
    expect_out("wrap0", 32'h00000583, 9'd0, 1'b0);
    out_ready = 1'b0;
    redir("r0", 9'd0);
    tick(3);
    chk("bp_fetch", 32'(fetch_addr), 32'd8);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_inst", out_inst, 32'h00000583);
    isInst = 1'b0;
    tick();
    isInst = 1'b1;
    tick(2);
    chk("bp_fetch_hold", 32'(fetch_addr), 32'd8);
    chk("bp_inst_hold", out_inst, 32'h00000583);
    chk("bp_pc_hold", 32'(out_pc), 32'd0);
    out_ready = 1'b1;
    expect_out("bp0", 32'h00000583, 9'd0, 1'b0);
    expect_out("bp4", 32'h00401603, 9'd4, 1'b0);
    expect_out("bp8", 32'h00C58593, 9'd8, 1'b0);
    expect_out("bp12", 32'h00010013, 9'd12, 1'b0);
    chk("co_valid", 32'(out_valid), 32'd1);
    redir("r100", 9'd100);
    expect_out("co100", 32'h00B50533, 9'd100, 1'b0);
    tick(2);
    chk("rs_pre", 32'(out_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("rs_valid", 32'(out_valid), 32'd0);
    chk("rs_fetch", 32'(fetch_addr), 32'd0);
    chk("rs_pc", 32'(out_pc), 32'd0);
    chk("rs_inst", out_inst, 32'd0);
    tick();
    rst = 1'b1;
    expect_out("rs0", 32'h00000583, 9'd0, 1'b0);
    expect_out("rs4", 32'h00401603, 9'd4, 1'b0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
